// File: rtl/rv2t_decode_pkg.sv
// Shared constants for the RV2T decode queue: opcode map, SYSTEM funct3 codes
// and the bit layout of the ctl_* control bundle.
package rv2t_decode_pkg;

    localparam logic [6:0] CMD_OP_IMM   = 7'b0010011;
    localparam logic [6:0] CMD_OP       = 7'b0110011;
    localparam logic [6:0] CMD_LUI      = 7'b0110111;
    localparam logic [6:0] CMD_AUIPC    = 7'b0010111;
    localparam logic [6:0] CMD_JAL      = 7'b1101111;
    localparam logic [6:0] CMD_JALR     = 7'b1100111;
    localparam logic [6:0] CMD_BRANCH   = 7'b1100011;
    localparam logic [6:0] CMD_LOAD     = 7'b0000011;
    localparam logic [6:0] CMD_STORE    = 7'b0100011;
    localparam logic [6:0] CMD_SYSTEM   = 7'b1110011;
    localparam logic [6:0] CMD_MISC_MEM = 7'b0001111;

    localparam logic [2:0] SYS_F3_PRIV    = 3'b000;
    localparam logic [2:0] SYS_F3_CSRRW   = 3'b001;
    localparam logic [2:0] SYS_F3_CSRRS   = 3'b010;
    localparam logic [2:0] SYS_F3_CSRRC   = 3'b011;
    localparam logic [2:0] SYS_F3_ILLEGAL = 3'b100;
    localparam logic [2:0] SYS_F3_CSRRWI  = 3'b101;
    localparam logic [2:0] SYS_F3_CSRRSI  = 3'b110;
    localparam logic [2:0] SYS_F3_CSRRCI  = 3'b111;

    localparam int CTL_LOAD_X_RS1     = 0;
    localparam int CTL_LOAD_X_RS2     = 1;
    localparam int CTL_OP_IMM         = 2;
    localparam int CTL_OP             = 3;
    localparam int CTL_LUI            = 4;
    localparam int CTL_AUIPC          = 5;
    localparam int CTL_JAL            = 6;
    localparam int CTL_JALR           = 7;
    localparam int CTL_BRANCH         = 8;
    localparam int CTL_LOAD           = 9;
    localparam int CTL_STORE          = 10;
    localparam int CTL_SYSTEM         = 11;
    localparam int CTL_MISC_MEM       = 12;
    localparam int CTL_ALU_FUNCT3     = 13;
    localparam int CTL_MUL_DIV_FUNCT3 = 14;
    localparam int CTL_SAVE_TO_RD     = 15;
    localparam int CTL_CSR            = 16;
    localparam int CTL_CSR_WRITE      = 17;
    localparam int CTL_MRET           = 18;
    localparam int CTL_WFI            = 19;
    localparam int CTL_W              = 20;

    typedef logic [CTL_W-1:0] ctl_t;

endpackage

// File: rtl/rv2t_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the RV2T decode queue.
// The slave modport is the decode queue itself; master is its environment.
interface rv2t_decode_queue_if #(
    parameter int XLEN        = 32,
    parameter int PC_BITWIDTH = 32,
    parameter int DEPTH       = 2
);
    import rv2t_decode_pkg::*;

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_IR;
    logic [PC_BITWIDTH-1:0]   in_PC;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [11:0]              csr;
    logic                     csr_read_enable;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-3:0]          out_IR;
    logic [PC_BITWIDTH-1:0]   out_PC;
    logic [CTL_W-1:0]         out_ctl;
    logic                     out_illegal;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output flush, in_valid, in_IR, in_PC, out_ready,
        input  in_ready, rs1, rs2, csr, csr_read_enable,
               out_valid, out_IR, out_PC, out_ctl, out_illegal, occupancy
    );

    modport slave (
        input  flush, in_valid, in_IR, in_PC, out_ready,
        output in_ready, rs1, rs2, csr, csr_read_enable,
               out_valid, out_IR, out_PC, out_ctl, out_illegal, occupancy
    );

endinterface

// File: rtl/rv2t_decode_logic.sv
// Purely combinational RV32 decoder: IR -> control bundle, illegal flag and
// CSR read gating. Illegal instructions always present an all-zero bundle.
module rv2t_decode_logic
    import rv2t_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [XLEN-1:0] ir,
    output ctl_t            ctl,
    output logic            illegal,
    output logic            csr_read_enable
);
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [11:0] funct12_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rd_s;
    ctl_t        ctl_raw_s;
    logic        illegal_raw_s;
    logic        skip_read_s;

    assign opcode_s  = ir[6:0];
    assign funct3_s  = ir[14:12];
    assign funct7_s  = ir[31:25];
    assign funct12_s = ir[31:20];
    assign rs1_s     = ir[19:15];
    assign rd_s      = ir[11:7];

    // Opcode map to raw control bits plus opcode-specific legality
    always_comb begin
        ctl_raw_s     = '0;
        illegal_raw_s = 1'b0;
        case (opcode_s)
            CMD_OP_IMM: begin
                ctl_raw_s[CTL_OP_IMM]     = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1] = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
            end
            CMD_OP: begin
                ctl_raw_s[CTL_OP]             = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1]     = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS2]     = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD]     = 1'b1;
                ctl_raw_s[CTL_ALU_FUNCT3]     = ~ir[25];
                ctl_raw_s[CTL_MUL_DIV_FUNCT3] = ir[25];
                if (funct7_s == 7'b0000001) begin
                    illegal_raw_s = ~ENABLE_M;
                end else if ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) begin
                    illegal_raw_s = 1'b0;
                end else begin
                    illegal_raw_s = 1'b1;
                end
            end
            CMD_LUI: begin
                ctl_raw_s[CTL_LUI]        = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
            end
            CMD_AUIPC: begin
                ctl_raw_s[CTL_AUIPC]      = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
            end
            CMD_JAL: begin
                ctl_raw_s[CTL_JAL]        = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
            end
            CMD_JALR: begin
                ctl_raw_s[CTL_JALR]       = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1] = 1'b1;
                ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
            end
            CMD_BRANCH: begin
                ctl_raw_s[CTL_BRANCH]     = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1] = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS2] = 1'b1;
            end
            CMD_LOAD: begin
                ctl_raw_s[CTL_LOAD]       = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1] = 1'b1;
            end
            CMD_STORE: begin
                ctl_raw_s[CTL_STORE]      = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS1] = 1'b1;
                ctl_raw_s[CTL_LOAD_X_RS2] = 1'b1;
            end
            CMD_SYSTEM: begin
                ctl_raw_s[CTL_SYSTEM] = 1'b1;
                if (funct3_s == SYS_F3_PRIV) begin
                    // Only the low five funct12 bits select MRET/WFI
                    if (funct12_s[4:0] == 5'b00010) begin
                        ctl_raw_s[CTL_MRET] = 1'b1;
                    end else if (funct12_s[4:0] == 5'b00101) begin
                        ctl_raw_s[CTL_WFI] = 1'b1;
                    end else if ((funct12_s == 12'h000) || (funct12_s == 12'h001)) begin
                        illegal_raw_s = 1'b0;
                    end else begin
                        illegal_raw_s = 1'b1;
                    end
                end else if (funct3_s == SYS_F3_ILLEGAL) begin
                    illegal_raw_s = 1'b1;
                end else begin
                    ctl_raw_s[CTL_CSR]        = 1'b1;
                    ctl_raw_s[CTL_SAVE_TO_RD] = 1'b1;
                    ctl_raw_s[CTL_CSR_WRITE]  = |rs1_s;
                    ctl_raw_s[CTL_LOAD_X_RS1] = ~funct3_s[2];
                end
            end
            CMD_MISC_MEM: begin
                if (funct3_s == 3'b001) begin
                    ctl_raw_s[CTL_MISC_MEM] = 1'b1;
                end else begin
                    ctl_raw_s[CTL_MISC_MEM] = 1'b0;
                end
            end
            default: begin
                illegal_raw_s = 1'b1;
            end
        endcase
    end

    assign illegal = illegal_raw_s | (ir[1:0] != 2'b11);
    assign ctl     = illegal ? '0 : ctl_raw_s;

    // CSRRW/CSRRWI writing x0 never observe the old CSR value
    assign skip_read_s     = ((funct3_s == SYS_F3_CSRRW) || (funct3_s == SYS_F3_CSRRWI)) && (rd_s == 5'd0);
    assign csr_read_enable = ctl[CTL_CSR] & ~skip_read_s;

endmodule

// File: rtl/rv2t_decode_queue.sv
// RV2T decode stage: DEPTH-entry instruction queue, head-entry decode and a
// registered valid/ready output stage towards execute.
module rv2t_decode_queue
    import rv2t_decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_BITWIDTH = 32,
    parameter int DEPTH       = 2,
    parameter bit ENABLE_M    = 1'b1
) (
    input logic                 clk,
    input logic                 sync_reset,
    rv2t_decode_queue_if.slave  bus
);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]        ir_mem_r [DEPTH];
    logic [PC_BITWIDTH-1:0] pc_mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic [XLEN-1:0]        head_ir_s;
    logic [PC_BITWIDTH-1:0] head_pc_s;
    logic                   not_empty_s;
    logic                   in_ready_s;
    logic                   push_s;
    logic                   pop_s;
    ctl_t                   dec_ctl_s;
    logic                   dec_illegal_s;
    logic                   dec_csr_read_s;

    logic                   out_valid_r;
    logic [XLEN-3:0]        out_ir_r;
    logic [PC_BITWIDTH-1:0] out_pc_r;
    ctl_t                   out_ctl_r;
    logic                   out_illegal_r;

    assign head_ir_s   = ir_mem_r[rd_ptr_r];
    assign head_pc_s   = pc_mem_r[rd_ptr_r];
    assign not_empty_s = (count_r != {CNT_W{1'b0}});
    // A full queue refuses input even when it pops in the same cycle
    assign in_ready_s  = (count_r != FULL_COUNT) & ~bus.flush;
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = not_empty_s & (bus.out_ready | ~out_valid_r);

    rv2t_decode_logic #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .ir              (head_ir_s),
        .ctl             (dec_ctl_s),
        .illegal         (dec_illegal_s),
        .csr_read_enable (dec_csr_read_s)
    );

    // Queue storage; entries are never read while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            ir_mem_r[wr_ptr_r] <= bus.in_IR;
            pc_mem_r[wr_ptr_r] <= bus.in_PC;
        end
    end

    // Queue pointers and occupancy; flush discards every entry
    always_ff @(posedge clk) begin
        if (sync_reset || bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output stage: load on pop, retire on handshake, hold under stall
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            out_valid_r   <= 1'b0;
            out_ir_r      <= {(XLEN-2){1'b0}};
            out_pc_r      <= {PC_BITWIDTH{1'b0}};
            out_ctl_r     <= '0;
            out_illegal_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (pop_s) begin
            out_valid_r   <= 1'b1;
            out_ir_r      <= head_ir_s[XLEN-1:2];
            out_pc_r      <= head_pc_s;
            out_ctl_r     <= dec_ctl_s;
            out_illegal_r <= dec_illegal_s;
        end else if (bus.out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.rs1             = head_ir_s[19:15];
    assign bus.rs2             = head_ir_s[24:20];
    assign bus.csr             = head_ir_s[31:20];
    assign bus.csr_read_enable = dec_csr_read_s & not_empty_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_IR          = out_ir_r;
    assign bus.out_PC          = out_pc_r;
    assign bus.out_ctl         = out_ctl_r;
    assign bus.out_illegal     = out_illegal_r;
    assign bus.occupancy       = count_r;

endmodule
